// File: rtl/wb_pkg.sv
// Shared types and constants for the register writeback queue and its
// forwarding lookup.
package wb_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first match of one read address against the pending queue
// entries (walked from head toward tail) and the register-file output stage.
module wb_fwd_match
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int ADDR_W = wb_pkg::ADDR_W
) (
   input  logic [ADDR_W-1:0]             i_addr,
   input  logic [DEPTH-1:0][ADDR_W-1:0]  i_rd,
   input  logic [DEPTH-1:0][DATA_W-1:0]  i_data,
   input  logic [$clog2(DEPTH)-1:0]      i_head,
   input  logic [$clog2(DEPTH):0]        i_count,
   input  logic                          i_out_valid,
   input  logic [ADDR_W-1:0]             i_out_rd,
   input  logic [DATA_W-1:0]             i_out_data,
   output logic                          o_hit,
   output logic [DATA_W-1:0]             o_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]     w_idx;
   logic              w_match;
   logic              w_hit;
   logic [DATA_W-1:0] w_data;

   // Output stage is oldest; later (younger) queue matches overwrite earlier ones.
   always_comb begin
      w_hit   = i_out_valid && (i_out_rd == i_addr);
      w_data  = i_out_data;
      w_idx   = '0;
      w_match = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx   = i_head + PW'(k);
         w_match = (CW'(k) < i_count) && (i_rd[w_idx] == i_addr);
         w_hit   = w_hit | w_match;
         w_data  = w_match ? i_data[w_idx] : w_data;
      end
      o_hit  = w_hit && (i_addr != ADDR_W'(REG_ZERO));
      o_data = o_hit ? w_data : '0;
   end
endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback buffer feeding the single register-file write port,
// with youngest-value forwarding for both decode read ports.
module reg_writeback_queue
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int ADDR_W = wb_pkg::ADDR_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_rd,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       drain_hold,
   output logic                       write_en,
   output logic [ADDR_W-1:0]          WriteAdd,
   output logic [DATA_W-1:0]          Reg_WriteData,
   input  logic [ADDR_W-1:0]          ReadAdd1,
   input  logic [ADDR_W-1:0]          ReadAdd2,
   output logic                       fwd_hit1,
   output logic                       fwd_hit2,
   output logic [DATA_W-1:0]          fwd_data1,
   output logic [DATA_W-1:0]          fwd_data2,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][ADDR_W-1:0] r_rd;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;
   logic [PW-1:0]                r_head;
   logic [PW-1:0]                r_tail;
   logic [CW-1:0]                r_count;
   logic                         w_push;
   logic                         w_pop;

   assign count    = r_count;
   assign in_ready = (r_count < CW'(DEPTH));
   // x0 writes complete the handshake but are dropped here.
   assign w_push   = in_valid && in_ready && (in_rd != ADDR_W'(REG_ZERO));
   assign w_pop    = (r_count != '0) && !drain_hold;

   // Entry storage; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_rd[r_tail]   <= in_rd;
         r_data[r_tail] <= in_data;
      end
   end

   // Pointers, occupancy and the registered write-port stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         write_en      <= 1'b0;
         WriteAdd      <= '0;
         Reg_WriteData <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1'b1);
         end
         if (w_pop) begin
            write_en      <= 1'b1;
            WriteAdd      <= r_rd[r_head];
            Reg_WriteData <= r_data[r_head];
            r_head        <= r_head + PW'(1'b1);
         end else begin
            write_en      <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1'b1);
            2'b01:   r_count <= r_count - CW'(1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
      .i_addr      (ReadAdd1),
      .i_rd        (r_rd),
      .i_data      (r_data),
      .i_head      (r_head),
      .i_count     (r_count),
      .i_out_valid (write_en),
      .i_out_rd    (WriteAdd),
      .i_out_data  (Reg_WriteData),
      .o_hit       (fwd_hit1),
      .o_data      (fwd_data1)
   );

   wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
      .i_addr      (ReadAdd2),
      .i_rd        (r_rd),
      .i_data      (r_data),
      .i_head      (r_head),
      .i_count     (r_count),
      .i_out_valid (write_en),
      .i_out_rd    (WriteAdd),
      .i_out_data  (Reg_WriteData),
      .o_hit       (fwd_hit2),
      .o_data      (fwd_data2)
   );
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed and random checks of reg_writeback_queue against a scoreboard
// of pending writes and a reference register file.
module tb_reg_writeback_queue;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, drain_hold, write_en;
   logic [4:0]  in_rd, WriteAdd, ReadAdd1, ReadAdd2;
   logic [31:0] in_data, Reg_WriteData, fwd_data1, fwd_data2;
   logic        fwd_hit1, fwd_hit2;
   logic [2:0]  count;

   always #5 clk = ~clk;

   reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .drain_hold(drain_hold),
      .write_en(write_en), .WriteAdd(WriteAdd), .Reg_WriteData(Reg_WriteData),
      .ReadAdd1(ReadAdd1), .ReadAdd2(ReadAdd2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
   );

   wb_entry_t   sb[$];
   int          qcnt = 0;
   logic        outv = 1'b0;
   logic [31:0] rf[32];
   logic [31:0] exp_rf[32];
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [32:0] ref_fwd(input logic [4:0] a);
      if (a != 5'd0) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].rd == a) return {1'b1, sb[i].data};
         end
      end
      return 33'd0;
   endfunction

   // Reference: commits, scoreboard push/pop and the register file at each edge.
   always @(posedge clk) begin
      logic      push, pop;
      wb_entry_t e;
      if (write_en === 1'b1) rf[WriteAdd] = Reg_WriteData;
      if (outv) begin
         e = sb.pop_front();
         chk("wr_addr", {27'd0, WriteAdd}, {27'd0, e.rd});
         chk("wr_data", Reg_WriteData, e.data);
         exp_rf[e.rd] = e.data;
      end
      if (reset) begin
         sb.delete();
         qcnt = 0;
         outv = 1'b0;
      end else begin
         push = in_valid && (qcnt < DEPTH) && (in_rd != 5'd0);
         pop  = (qcnt > 0) && !drain_hold;
         if (push) sb.push_back(wb_entry_t'({in_rd, in_data}));
         outv = pop;
         qcnt = qcnt + int'(push) - int'(pop);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state();
      logic [32:0] f1, f2;
      f1 = ref_fwd(ReadAdd1);
      f2 = ref_fwd(ReadAdd2);
      chk("count", {29'd0, count}, 32'(qcnt));
      chk("write_en", {31'd0, write_en}, {31'd0, outv});
      chk("in_ready", {31'd0, in_ready}, (qcnt < DEPTH) ? 32'd1 : 32'd0);
      chk("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, f1[32]});
      chk("fwd_data1", fwd_data1, f1[31:0]);
      chk("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, f2[32]});
      chk("fwd_data2", fwd_data2, f2[31:0]);
   endtask

   initial begin
      for (int a = 0; a < 32; a++) begin
         rf[a]     = 32'd0;
         exp_rf[a] = 32'd0;
      end
      reset = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_data = 32'd0;
      drain_hold = 1'b0; ReadAdd1 = 5'd5; ReadAdd2 = 5'd7;
      tick();
      tick();
      chk("rst_write_en", {31'd0, write_en}, 32'd0);
      chk("rst_WriteAdd", {27'd0, WriteAdd}, 32'd0);
      chk("rst_WriteData", Reg_WriteData, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_fwd_hit1", {31'd0, fwd_hit1}, 32'd0);
      chk("rst_fwd_data2", fwd_data2, 32'd0);
      reset = 1'b0;

      // Single write latency and forwarding window
      in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF;
      tick();
      in_valid = 1'b0;
      chk("lat_count", {29'd0, count}, 32'd1);
      chk("lat_we_n", {31'd0, write_en}, 32'd0);
      chk("lat_hit_n", {31'd0, fwd_hit1}, 32'd1);
      check_state();
      tick();
      chk("lat_we_n1", {31'd0, write_en}, 32'd1);
      chk("lat_addr_n1", {27'd0, WriteAdd}, 32'd5);
      chk("lat_data_n1", Reg_WriteData, 32'hDEADBEEF);
      chk("lat_fwd_n1", fwd_data1, 32'hDEADBEEF);
      tick();
      chk("lat_we_n2", {31'd0, write_en}, 32'd0);
      chk("lat_hit_n2", {31'd0, fwd_hit1}, 32'd0);
      chk("lat_data1_n2", fwd_hit1 ? fwd_data1 : rf[5], 32'hDEADBEEF);

      // Fill under hold, reject when full, drain in order
      drain_hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
         tick();
      end
      in_rd = 5'd9; in_data = 32'h999;
      chk("full_count", {29'd0, count}, 32'd4);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("full_reject", {29'd0, count}, 32'd4);
      in_valid = 1'b0;
      check_state();
      drain_hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("drain_we", {31'd0, write_en}, 32'd1);
         chk("drain_addr", {27'd0, WriteAdd}, 32'(i));
      end
      tick();
      chk("drain_idle", {31'd0, write_en}, 32'd0);

      // Same register twice: youngest forwards, last value lands
      drain_hold = 1'b1;
      in_valid = 1'b1; in_rd = 5'd7; in_data = 32'h11;
      tick();
      in_data = 32'h22;
      tick();
      in_valid = 1'b0; ReadAdd2 = 5'd7;
      chk("dup_hit2", {31'd0, fwd_hit2}, 32'd1);
      chk("dup_fwd2", fwd_data2, 32'h22);
      check_state();
      drain_hold = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("dup_rf7", rf[7], 32'h22);

      // Writes to x0 are accepted but dropped
      in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFFFFFF;
      ReadAdd1 = 5'd0; ReadAdd2 = 5'd0;
      chk("x0_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("x0_count", {29'd0, count}, 32'd0);
      chk("x0_hit1", {31'd0, fwd_hit1}, 32'd0);
      chk("x0_hit2", {31'd0, fwd_hit2}, 32'd0);
      tick();
      chk("x0_we", {31'd0, write_en}, 32'd0);

      // Reset discards pending entries
      drain_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 32'hA0 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_count", {29'd0, count}, 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0; drain_hold = 1'b0;
      chk("mid_rst_count", {29'd0, count}, 32'd0);
      chk("mid_rst_we", {31'd0, write_en}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_we", {31'd0, write_en}, 32'd0);
      end
      for (int i = 10; i <= 12; i++) chk("post_rst_rf", rf[i], 32'd0);

      // Random push/hold stream
      for (int c = 0; c < 1000; c++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_rd      = 5'($urandom_range(0, 7));
         in_data    = $urandom;
         drain_hold = ($urandom_range(0, 9) < 3);
         ReadAdd1   = 5'($urandom_range(0, 7));
         ReadAdd2   = 5'($urandom_range(0, 7));
         tick();
         check_state();
      end
      in_valid = 1'b0; drain_hold = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check_state();
      for (int a = 1; a < 32; a++) chk("final_rf", rf[a], exp_rf[a]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
